bus_arbiter_rr4: RTL

- Round-robin arbiter that shares one resource (the shared result/write-back bus) among four requesters.
- Grants are registered, with a bounded hold time and an optional lock.
- The granted index drives a decoder_2x4 instance, which produces the one-hot grant vector.
- Sits between the execution units and the shared bus.

---
 rtl/bus_arbiter_rr4_pkg.sv | 30 +++
 rtl/bus_arbiter_rr4_decoder_2x4.sv | 14 +
 rtl/bus_arbiter_rr4.sv | 82 ++++++++
 3 files changed

// File: rtl/bus_arbiter_rr4_pkg.sv
// Shared constants, FSM state type and rotate-search helper for the
// four-way round-robin bus arbiter.
package bus_arbiter_rr4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // Returns the first set bit of vec found searching upward from start with
  // wrap; returns start when vec is empty. Scanning downward lets the
  // nearest hit be the last assignment, so no early exit is needed.
  function automatic logic [IDX_W-1:0] next_idx(
    input logic [NUM_REQ-1:0] vec,
    input logic [IDX_W-1:0]   start
  );
    logic [IDX_W-1:0] idx;
    next_idx = start;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      idx = start + IDX_W'(k - 1);
      if (vec[idx]) begin
        next_idx = idx;
      end
    end
  endfunction

endpackage

// File: rtl/bus_arbiter_rr4_decoder_2x4.sv
// Two-to-four one-hot decoder used to form the grant vector.
module decoder_2x4
  import bus_arbiter_rr4_pkg::*;
(
  output logic [NUM_REQ-1:0] Y,
  input  logic [IDX_W-1:0]   s
);

  always_comb begin
    Y    = '0;
    Y[s] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter_rr4.sv
// Round-robin arbiter for four requesters sharing the write-back bus, with
// registered grants, bounded hold time and an owner lock.
module bus_arbiter_rr4
  import bus_arbiter_rr4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 lock,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_valid,
  output logic                 timeout
);

  arb_state_t         state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [IDX_W-1:0]   last_owner;
  logic [NUM_REQ-1:0] dec_y;
  logic [NUM_REQ-1:0] others;
  logic               hold_max;

  decoder_2x4 u_dec (
    .Y (dec_y),
    .s (gnt_idx)
  );

  always_comb begin
    gnt      = gnt_valid ? dec_y : '0;
    others   = req & ~dec_y;
    hold_max = (hold_cnt == CNT_W'(MAX_HOLD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt_idx    <= '0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt_idx   <= next_idx(req, last_owner + IDX_W'(1));
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!req[gnt_idx]) begin
            // Voluntary release wins over a simultaneous hold expiry.
            last_owner <= gnt_idx;
            hold_cnt   <= '0;
            if (|req) begin
              gnt_idx <= next_idx(req, gnt_idx + IDX_W'(1));
            end else begin
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end else if (hold_max && (|others) && !lock) begin
            last_owner <= gnt_idx;
            gnt_idx    <= next_idx(others, gnt_idx + IDX_W'(1));
            hold_cnt   <= '0;
            timeout    <= 1'b1;
          end else if (!hold_max) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
